// File: rtl/input_index_dispatcher_pkg.sv
// Shared types and defaults for the input-layer index dispatcher.
package input_index_dispatcher_pkg;

    localparam int unsigned NUM_GROUPS_DEF = 4;
    localparam int unsigned IDX_W_DEF      = 10;
    localparam int unsigned CNT_W_DEF      = 10;
    localparam int unsigned TIMEOUT_DEF    = 1024;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_FINISH   = 2'd3
    } disp_state_e;

    // Watchdog counter width; it only has to reach TIMEOUT_CYCLES-1.
    function automatic int unsigned wd_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/input_index_dispatcher_if.sv
// Queue-side and group-side signals of the index dispatcher.
interface input_index_dispatcher_if
    import input_index_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
);
    logic                  outputs_ready;
    logic                  queue_empty;
    logic [IDX_W-1:0]      index_in;
    logic                  dequeue;
    logic                  index_valid;
    logic [IDX_W-1:0]      index_out;
    logic [NUM_GROUPS-1:0] grp_ack;
    logic                  frame_done;
    logic [CNT_W-1:0]      active_count;
    logic                  timeout_err;
    logic                  busy;

    modport master (
        input  outputs_ready, queue_empty, index_in, grp_ack,
        output dequeue, index_valid, index_out, frame_done, active_count, timeout_err, busy
    );

    modport slave (
        output outputs_ready, queue_empty, index_in, grp_ack,
        input  dequeue, index_valid, index_out, frame_done, active_count, timeout_err, busy
    );
endinterface

// File: rtl/input_index_dispatcher_ack_collector.sv
// Sticky per-group ack mask; all_acked includes acks arriving this cycle.
module input_index_dispatcher_ack_collector
    import input_index_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [NUM_GROUPS-1:0] ack_i,
    output logic                  all_acked_c_o
);
    logic [NUM_GROUPS-1:0] mask_q;
    logic [NUM_GROUPS-1:0] mask_d;

    always_comb begin
        mask_d = mask_q;
        if (clear_i) begin
            mask_d = '0;
        end else if (en_i) begin
            mask_d = mask_q | ack_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign all_acked_c_o = en_i && ((mask_q | ack_i) == {NUM_GROUPS{TRUE}});

endmodule

// File: rtl/input_index_dispatcher.sv
// Drains the input index queue per frame and broadcasts each index to all
// hidden-layer groups, advancing once every group has acked it.
module input_index_dispatcher
    import input_index_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_GROUPS     = NUM_GROUPS_DEF,
    parameter int unsigned IDX_W          = IDX_W_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input_index_dispatcher_if.master  bus
);
    localparam int unsigned    WD_W    = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic            WD_EN   = (TIMEOUT_CYCLES != 0);

    disp_state_e      state_q, state_d;
    logic             rdy_q;
    logic [IDX_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             frame_done_q;
    logic             index_valid_q;
    logic             busy_q;

    logic start_c;
    logic ack_en_c;
    logic ack_clear_c;
    logic all_acked_c;
    logic dequeue_c;

    assign start_c  = bus.outputs_ready && !rdy_q;
    assign ack_en_c = (state_q == ST_WAIT_ACK);

    input_index_dispatcher_ack_collector #(
        .NUM_GROUPS (NUM_GROUPS)
    ) u_ack_collector (
        .clk           (clk),
        .rst_n         (reset),
        .clear_i       (ack_clear_c),
        .en_i          (ack_en_c),
        .ack_i         (bus.grp_ack),
        .all_acked_c_o (all_acked_c)
    );

    // Next-state logic; completion takes priority over watchdog expiry.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        wd_d        = '0;
        ack_clear_c = FALSE;
        dequeue_c   = FALSE;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d     = ST_FETCH;
                    cnt_d       = '0;
                    terr_d      = FALSE;
                    ack_clear_c = TRUE;
                end
            end
            ST_FETCH: begin
                if (bus.queue_empty) begin
                    state_d = ST_FINISH;
                end else begin
                    index_d   = bus.index_in;
                    dequeue_c = TRUE;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (all_acked_c) begin
                    ack_clear_c = TRUE;
                    cnt_d       = (cnt_q == {CNT_W{TRUE}}) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d     = ST_FETCH;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    ack_clear_c = TRUE;
                    terr_d      = TRUE;
                    state_d     = ST_FINISH;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rdy_q         <= FALSE;
            index_q       <= '0;
            cnt_q         <= '0;
            terr_q        <= FALSE;
            wd_q          <= '0;
            frame_done_q  <= FALSE;
            index_valid_q <= FALSE;
            busy_q        <= FALSE;
        end else begin
            state_q       <= state_d;
            rdy_q         <= bus.outputs_ready;
            index_q       <= index_d;
            cnt_q         <= cnt_d;
            terr_q        <= terr_d;
            wd_q          <= wd_d;
            frame_done_q  <= (state_d == ST_FINISH);
            index_valid_q <= (state_d == ST_WAIT_ACK);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    // The pop must coincide with FETCH, so dequeue is decoded from state.
    assign bus.dequeue      = dequeue_c;
    assign bus.index_valid  = index_valid_q;
    assign bus.index_out    = index_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.active_count = cnt_q;
    assign bus.timeout_err  = terr_q;
    assign bus.busy         = busy_q;

endmodule
